// File: rtl/beat_sequencer.sv
// Beat/phase sequencer: one-hot T1..T3 phases inside one-hot W1..W3 beats, plus IR/C/Z latches loaded at T3.
// Optional macro BEAT_SEQ_SINGLE_STEP_EN adds i_step, which halts after every beat like STOP.
module beat_sequencer (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_qd,
    input  logic       i_short,
    input  logic       i_long,
    input  logic       i_stop,
`ifdef BEAT_SEQ_SINGLE_STEP_EN
    input  logic       i_step,
`endif
    input  logic       i_lir,
    input  logic       i_ldc,
    input  logic       i_ldz,
    input  logic [3:0] i_ir_in,
    input  logic       i_c_next,
    input  logic       i_z_next,
    output logic [2:0] o_t,
    output logic [2:0] o_w,
    output logic [3:0] o_ir,
    output logic       o_c,
    output logic       o_z,
    output logic       o_run
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [2:0] PH1 = 3'b001;
    localparam logic [2:0] PH2 = 3'b010;
    localparam logic [2:0] PH3 = 3'b100;

    state_t     r_state;
    logic [2:0] r_t;
    logic [2:0] r_w;
    logic [3:0] r_ir;
    logic       r_c;
    logic       r_z;
    logic       r_run;

    logic       w_halt;
    logic [2:0] w_w_next;

`ifdef BEAT_SEQ_SINGLE_STEP_EN
    assign w_halt = i_stop | i_step;
`else
    assign w_halt = i_stop;
`endif

    // SHORT wins over LONG at W1; LONG only matters at W2.
    always_comb begin
        w_w_next = PH1;
        case (r_w)
            PH1:     w_w_next = i_short ? PH1 : PH2;
            PH2:     w_w_next = i_long  ? PH3 : PH1;
            default: w_w_next = PH1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= ST_IDLE;
            r_t     <= 3'b000;
            r_w     <= PH1;
            r_ir    <= 4'b0000;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_qd) begin
                        r_state <= ST_ACTIVE;
                        r_t     <= PH1;
                        r_run   <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    case (r_t)
                        PH1: r_t <= PH2;
                        PH2: r_t <= PH3;
                        PH3: begin
                            r_w <= w_w_next;
                            if (i_lir) r_ir <= i_ir_in;
                            if (i_ldc) r_c  <= i_c_next;
                            if (i_ldz) r_z  <= i_z_next;
                            if (w_halt) begin
                                r_state <= ST_IDLE;
                                r_t     <= 3'b000;
                                r_run   <= 1'b0;
                            end else begin
                                r_t     <= PH1;
                            end
                        end
                        default: r_t <= PH1;
                    endcase
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_t     <= 3'b000;
                    r_run   <= 1'b0;
                end
            endcase
        end
    end

    assign o_t   = r_t;
    assign o_w   = r_w;
    assign o_ir  = r_ir;
    assign o_c   = r_c;
    assign o_z   = r_z;
    assign o_run = r_run;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer; checks outputs 1ns after each rising edge.
module tb_beat_sequencer;

    logic       clk = 1'b0;
    logic       clr = 1'b0, qd = 1'b0, short_i = 1'b0, long_i = 1'b0, stop = 1'b0;
    logic       lir = 1'b0, ldc = 1'b0, ldz = 1'b0, c_next = 1'b0, z_next = 1'b0;
    logic [3:0] ir_in = 4'b0000;
`ifdef BEAT_SEQ_SINGLE_STEP_EN
    logic       step = 1'b0;
`endif
    logic [2:0] t, w;
    logic [3:0] ir;
    logic       c, z, run;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    beat_sequencer dut (
        .i_clk    (clk),
        .i_clr    (clr),
        .i_qd     (qd),
        .i_short  (short_i),
        .i_long   (long_i),
        .i_stop   (stop),
`ifdef BEAT_SEQ_SINGLE_STEP_EN
        .i_step   (step),
`endif
        .i_lir    (lir),
        .i_ldc    (ldc),
        .i_ldz    (ldz),
        .i_ir_in  (ir_in),
        .i_c_next (c_next),
        .i_z_next (z_next),
        .o_t      (t),
        .o_w      (w),
        .o_ir     (ir),
        .o_c      (c),
        .o_z      (z),
        .o_run    (run)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] et, input logic [2:0] ew,
                             input logic [3:0] eir, input logic ec, input logic ez, input logic erun);
        check({tag, ".t"},   {5'd0, t},   {5'd0, et});
        check({tag, ".w"},   {5'd0, w},   {5'd0, ew});
        check({tag, ".ir"},  {4'd0, ir},  {4'd0, eir});
        check({tag, ".c"},   {7'd0, c},   {7'd0, ec});
        check({tag, ".z"},   {7'd0, z},   {7'd0, ez});
        check({tag, ".run"}, {7'd0, run}, {7'd0, erun});
    endtask

    initial begin
        // Reset, with QD and loads asserted to show CLR overrides them
        clr = 1'b1; qd = 1'b1; lir = 1'b1; ir_in = 4'hF;
        tick(1);
        check_all("reset", 3'b000, 3'b001, 4'h0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0; qd = 1'b0; lir = 1'b0; ir_in = 4'h0;
        tick(1);
        check_all("idle_hold", 3'b000, 3'b001, 4'h0, 1'b0, 1'b0, 1'b0);

        // SHORT: T cycles, W stays W1
        qd = 1'b1; short_i = 1'b1;
        tick(1);
        check_all("start", 3'b001, 3'b001, 4'h0, 1'b0, 1'b0, 1'b1);
        qd = 1'b0;
        tick(1); check_all("short_t2", 3'b010, 3'b001, 4'h0, 1'b0, 1'b0, 1'b1);
        tick(1); check_all("short_t3", 3'b100, 3'b001, 4'h0, 1'b0, 1'b0, 1'b1);
        long_i = 1'b1;  // SHORT has priority at W1
        tick(1); check_all("short_t1b", 3'b001, 3'b001, 4'h0, 1'b0, 1'b0, 1'b1);

        // LONG: W1 -> W2 -> W3 -> W1, three clocks per beat
        short_i = 1'b0;
        tick(2); check("long_w1_t3", {5'd0, t}, 8'h04);
        tick(1); check("long_w2", {5'd0, w}, 8'h02);
        tick(2); check("long_w2_hold", {5'd0, w}, 8'h02);
        tick(1); check("long_w3", {5'd0, w}, 8'h04);
        tick(2); check("long_w3_hold", {5'd0, w}, 8'h04);
        tick(1); check_all("long_w1", 3'b001, 3'b001, 4'h0, 1'b0, 1'b0, 1'b1);

        // Loads only on the edge ending T3
        long_i = 1'b0; short_i = 1'b1;
        ir_in = 4'b1010; lir = 1'b1; ldc = 1'b1; c_next = 1'b1; ldz = 1'b0; z_next = 1'b1;
        tick(1); check_all("load_t2", 3'b010, 3'b001, 4'h0, 1'b0, 1'b0, 1'b1);
        tick(1); check_all("load_t3", 3'b100, 3'b001, 4'h0, 1'b0, 1'b0, 1'b1);
        tick(1); check_all("load_done", 3'b001, 3'b001, 4'hA, 1'b1, 1'b0, 1'b1);
        lir = 1'b0; ldc = 1'b0; ldz = 1'b1; z_next = 1'b1; ir_in = 4'h5; c_next = 1'b0;
        tick(2); check("ldz_off_t3", {7'd0, z}, 8'h00);
        ldz = 1'b0;
        tick(1); check_all("ldz_none", 3'b001, 3'b001, 4'hA, 1'b1, 1'b0, 1'b1);

        // STOP ignored at T2, honoured at T3; W still advances
        short_i = 1'b0;
        tick(1);
        stop = 1'b1;
        tick(1); check_all("stop_t2", 3'b100, 3'b001, 4'hA, 1'b1, 1'b0, 1'b1);
        tick(1); check_all("stop_t3", 3'b000, 3'b010, 4'hA, 1'b1, 1'b0, 1'b0);
        stop = 1'b0;
        lir = 1'b1; ldc = 1'b1; ir_in = 4'h5; c_next = 1'b0;
        tick(2); check_all("idle_loads", 3'b000, 3'b010, 4'hA, 1'b1, 1'b0, 1'b0);
        lir = 1'b0; ldc = 1'b0;
        qd = 1'b1;
        tick(1); check_all("resume", 3'b001, 3'b010, 4'hA, 1'b1, 1'b0, 1'b1);
        tick(1); check("qd_active_ign", {5'd0, t}, 8'h02);
        qd = 1'b0;

        // Clear mid-beat at T2 of W3
        long_i = 1'b1; ir_in = 4'hF; lir = 1'b1;
        tick(2); check_all("to_w3", 3'b001, 3'b100, 4'hF, 1'b1, 1'b0, 1'b1);
        lir = 1'b0;
        tick(1); check("w3_t2", {5'd0, t}, 8'h02);
        clr = 1'b1; qd = 1'b1;
        tick(1); check_all("clr_mid", 3'b000, 3'b001, 4'h0, 1'b0, 1'b0, 1'b0);
        tick(1); check_all("clr_qd_ign", 3'b000, 3'b001, 4'h0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        tick(1); check_all("first_after_clr", 3'b001, 3'b001, 4'h0, 1'b0, 1'b0, 1'b1);
        qd = 1'b0; long_i = 1'b0;

`ifdef BEAT_SEQ_SINGLE_STEP_EN
        clr = 1'b1;
        tick(1);
        clr = 1'b0; step = 1'b1; long_i = 1'b1;
        begin
            logic [2:0] exp_w [3];
            exp_w[0] = 3'b010; exp_w[1] = 3'b100; exp_w[2] = 3'b001;
            for (int k = 0; k < 3; k++) begin
                qd = 1'b1;
                tick(1);
                qd = 1'b0;
                check("step_run", {7'd0, run}, 8'h01);
                tick(2);
                check("step_t3", {5'd0, t}, 8'h04);
                tick(1);
                check("step_w", {5'd0, w}, {5'd0, exp_w[k]});
                check("step_idle", {4'd0, run, t}, 8'h00);
                tick(2);
                check("step_stay", {4'd0, run, t}, 8'h00);
            end
        end
        step = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
